// File: rtl/t01_score_sevenseg.sv
// Score to 4-digit seven-segment display: iterative double-dabble (12 edges/conversion), leading-zero blanking.
// Optional game-over blink when T01_SSEG_BLINK_EN is defined; no backpressure, score changes are picked up in IDLE.
module t01_score_sevenseg #(
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [9:0]  score,
    input  logic        gameover,
    output logic        busy,
    output logic [15:0] bcd,
    output logic [7:0]  ss3,
    output logic [7:0]  ss2,
    output logic [7:0]  ss1,
    output logic [7:0]  ss0
);
    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t      state_q, state_d;
    logic [9:0]  last_score_q, last_score_d;
    logic [9:0]  cap_q, cap_d;
    logic [9:0]  shift_q, shift_d;
    logic [15:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] adj;
    logic        blink_blank;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                         : scratch_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        cap_d        = cap_q;
        shift_d      = shift_q;
        scratch_d    = scratch_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        case (state_q)
            IDLE: begin
                if (score != last_score_q) begin
                    cap_d     = score;
                    shift_d   = score;
                    scratch_d = 16'h0000;
                    cnt_d     = 4'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                // Adjust then shift the {scratch, shift} pair left by one.
                scratch_d = {adj[14:0], shift_q[9]};
                shift_d   = {shift_q[8:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd9) state_d = LATCH;
            end
            LATCH: begin
                bcd_d        = scratch_q;
                last_score_d = cap_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            last_score_q <= 10'd0;
            cap_q        <= 10'd0;
            shift_q      <= 10'd0;
            scratch_q    <= 16'h0000;
            cnt_q        <= 4'd0;
            bcd_q        <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            cap_q        <= cap_d;
            shift_q      <= shift_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
        end
    end

`ifdef T01_SSEG_BLINK_EN
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = 32'd0;
        blink_ph_d  = 1'b0;
        if (gameover) begin
            if (blink_cnt_q == BLINK_CYCLES - 1) begin
                blink_cnt_d = 32'd0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
                blink_ph_d  = blink_ph_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            blink_cnt_q <= 32'd0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blink_blank = blink_ph_q;
`else
    logic        unused_gameover;
    logic [31:0] unused_blink_cycles;
    assign unused_gameover     = gameover;
    assign unused_blink_cycles = BLINK_CYCLES;
    assign blink_blank         = 1'b0;
`endif

    assign busy = (state_q != IDLE);
    assign bcd  = bcd_q;

    always_comb begin
        ss3 = seg7(bcd_q[15:12]);
        ss2 = seg7(bcd_q[11:8]);
        ss1 = seg7(bcd_q[7:4]);
        ss0 = seg7(bcd_q[3:0]);
        if (bcd_q[15:12] == 4'd0) ss3 = 8'h00;
        if (bcd_q[15:8] == 8'd0)  ss2 = 8'h00;
        if (bcd_q[15:4] == 12'd0) ss1 = 8'h00;
        if (blink_blank) begin
            ss3 = 8'h00;
            ss2 = 8'h00;
            ss1 = 8'h00;
            ss0 = 8'h00;
        end
    end
endmodule
